// File: rtl/complex_butterfly_decoder.sv
// Recovers A=(S+D)/2 and B=(S-D)/2 from a complex (Sum, Diff) pair using one shared complex add/sub unit.
// A is presented first, then B, each held on the output until it is accepted; a new pair is accepted only in IDLE.
module complex_butterfly_decoder #(
    parameter int IN_WIDTH  = 13,
    parameter int OUT_WIDTH = 13,
    parameter int ROUND_EN  = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_Valid,
    output logic                 IN_Ready,
    input  logic [IN_WIDTH-1:0]  IN_Sum_Real,
    input  logic [IN_WIDTH-1:0]  IN_Sum_Img,
    input  logic [IN_WIDTH-1:0]  IN_Diff_Real,
    input  logic [IN_WIDTH-1:0]  IN_Diff_Img,
    output logic                 OUT_Valid,
    input  logic                 OUT_Ready,
    output logic [OUT_WIDTH-1:0] OUT_Real,
    output logic [OUT_WIDTH-1:0] OUT_Img,
    output logic                 OUT_Sel
);

    typedef enum logic [2:0] {
        IDLE,
        CALC_A,
        HOLD_A,
        CALC_B,
        HOLD_B
    } state_t;

    localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH+1)'(ROUND_EN != 0 ? 1 : 0);

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   s_re_q, s_re_d;
    logic [IN_WIDTH-1:0]   s_im_q, s_im_d;
    logic [IN_WIDTH-1:0]   d_re_q, d_re_d;
    logic [IN_WIDTH-1:0]   d_im_q, d_im_d;
    logic [OUT_WIDTH-1:0]  out_re_q, out_re_d;
    logic [OUT_WIDTH-1:0]  out_im_q, out_im_d;
    logic                  out_sel_q, out_sel_d;
    logic                  out_vld_q, out_vld_d;

    logic                  op_sub;
    logic                  in_rdy;
    logic signed [IN_WIDTH:0] a_re, b_re, a_im, b_im;
    logic signed [IN_WIDTH:0] r_re, r_im;
    logic                  unused_lsb;

    // Shared unit: one extra bit of headroom makes the halved result exact in OUT_WIDTH bits.
    always_comb begin
        a_re = {s_re_q[IN_WIDTH-1], s_re_q};
        b_re = {d_re_q[IN_WIDTH-1], d_re_q};
        a_im = {s_im_q[IN_WIDTH-1], s_im_q};
        b_im = {d_im_q[IN_WIDTH-1], d_im_q};
        if (op_sub) begin
            r_re = a_re - b_re + RND;
            r_im = a_im - b_im + RND;
        end else begin
            r_re = a_re + b_re + RND;
            r_im = a_im + b_im + RND;
        end
    end

    assign unused_lsb = ^{r_re[0], r_im[0]};

    always_comb begin
        state_d   = state_q;
        s_re_d    = s_re_q;
        s_im_d    = s_im_q;
        d_re_d    = d_re_q;
        d_im_d    = d_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_sel_d = out_sel_q;
        out_vld_d = out_vld_q;
        op_sub    = 1'b0;
        in_rdy    = 1'b0;

        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (IN_Valid) begin
                    s_re_d  = IN_Sum_Real;
                    s_im_d  = IN_Sum_Img;
                    d_re_d  = IN_Diff_Real;
                    d_im_d  = IN_Diff_Img;
                    state_d = CALC_A;
                end
            end
            CALC_A: begin
                out_re_d  = r_re[OUT_WIDTH:1];
                out_im_d  = r_im[OUT_WIDTH:1];
                out_sel_d = 1'b0;
                out_vld_d = 1'b1;
                state_d   = HOLD_A;
            end
            HOLD_A: begin
                if (OUT_Ready) begin
                    out_vld_d = 1'b0;
                    state_d   = CALC_B;
                end
            end
            CALC_B: begin
                op_sub    = 1'b1;
                out_re_d  = r_re[OUT_WIDTH:1];
                out_im_d  = r_im[OUT_WIDTH:1];
                out_sel_d = 1'b1;
                out_vld_d = 1'b1;
                state_d   = HOLD_B;
            end
            HOLD_B: begin
                if (OUT_Ready) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            s_re_q    <= '0;
            s_im_q    <= '0;
            d_re_q    <= '0;
            d_im_q    <= '0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_sel_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_re_q    <= s_re_d;
            s_im_q    <= s_im_d;
            d_re_q    <= d_re_d;
            d_im_q    <= d_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            out_sel_q <= out_sel_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign IN_Ready  = in_rdy;
    assign OUT_Valid = out_vld_q;
    assign OUT_Real  = out_re_q;
    assign OUT_Img   = out_im_q;
    assign OUT_Sel   = out_sel_q;

endmodule

// File: tb/tb_complex_butterfly_decoder.sv
// Directed bench for complex_butterfly_decoder: a floor instance and a rounding instance share all stimulus.
module tb_complex_butterfly_decoder;

    localparam int W = 13;

    logic         clk;
    logic         rst;
    logic         in_vld;
    logic         out_rdy;
    logic [W-1:0] sr, si, dr, di;

    logic         in_rdy0, o_vld0, o_sel0;
    logic [W-1:0] o_re0, o_im0;
    logic         in_rdy1, o_vld1, o_sel1;
    logic [W-1:0] o_re1, o_im1;

    int n_tests = 0;
    int n_fail  = 0;

    complex_butterfly_decoder #(.IN_WIDTH(W), .OUT_WIDTH(W), .ROUND_EN(0)) dut_floor (
        .CLK(clk), .RST(rst), .IN_Valid(in_vld), .IN_Ready(in_rdy0),
        .IN_Sum_Real(sr), .IN_Sum_Img(si), .IN_Diff_Real(dr), .IN_Diff_Img(di),
        .OUT_Valid(o_vld0), .OUT_Ready(out_rdy), .OUT_Real(o_re0), .OUT_Img(o_im0), .OUT_Sel(o_sel0)
    );

    complex_butterfly_decoder #(.IN_WIDTH(W), .OUT_WIDTH(W), .ROUND_EN(1)) dut_round (
        .CLK(clk), .RST(rst), .IN_Valid(in_vld), .IN_Ready(in_rdy1),
        .IN_Sum_Real(sr), .IN_Sum_Img(si), .IN_Diff_Real(dr), .IN_Diff_Img(di),
        .OUT_Valid(o_vld1), .OUT_Ready(out_rdy), .OUT_Real(o_re1), .OUT_Img(o_im1), .OUT_Sel(o_sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Integer reference: (x +/- y + rnd) floor-divided by 2, truncated to W bits.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input bit sub, input int rnd);
        int xi, yi, v;
        logic [31:0] vb;
        xi = int'($signed(x));
        yi = int'($signed(y));
        v  = sub ? (xi - yi + rnd) : (xi + yi + rnd);
        if (v < 0) v = -((-v + 1) / 2);
        else       v = v / 2;
        vb = v;
        return vb[W-1:0];
    endfunction

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input bit rnd_rdy, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
            if (in_rdy0) begin
                sr = a; si = b; dr = c; di = d;
                in_vld = 1'b1;
                step();
                in_vld = 1'b0;
                ok = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic wait_out(input bit rnd_rdy, output bit ok,
                            output logic [W-1:0] re0, output logic [W-1:0] im0, output logic sel0,
                            output logic [W-1:0] re1, output logic [W-1:0] im1, output logic sel1);
        ok = 1'b0;
        re0 = '0; im0 = '0; sel0 = 1'b0; re1 = '0; im1 = '0; sel1 = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
            if (o_vld0 && out_rdy) begin
                re0 = o_re0; im0 = o_im0; sel0 = o_sel0;
                re1 = o_re1; im1 = o_im1; sel1 = o_sel1;
                ok = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        sr = '0; si = '0; dr = '0; di = '0;
        repeat (2) step();
        n_tests++;
        if (o_vld0 !== 1'b0 || o_re0 !== 13'h0 || o_im0 !== 13'h0 || o_sel0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%b re=%h im=%h sel=%b, want 0 0 0 0", o_vld0, o_re0, o_im0, o_sel0);
        end
        n_tests++;
        if (in_rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_rdy0);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        out_rdy = 1'b1;
        send_pair(13'h0300, 13'h0200, 13'h0100, 13'h0000, 1'b0, ok);
        n_tests++;
        if (!ok || in_rdy0 !== 1'b0 || o_vld0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_calc_a: ok=%b in_rdy=%b vld=%b want 1 0 0", ok, in_rdy0, o_vld0);
        end
        step();
        n_tests++;
        if (o_vld0 !== 1'b1 || o_re0 !== 13'h0200 || o_im0 !== 13'h0100 || o_sel0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_a: vld=%b re=%h im=%h sel=%b want 1 0200 0100 0", o_vld0, o_re0, o_im0, o_sel0);
        end
        step();
        n_tests++;
        if (o_vld0 !== 1'b0 || in_rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_calc_b: vld=%b in_rdy=%b want 0 0", o_vld0, in_rdy0);
        end
        step();
        n_tests++;
        if (o_vld0 !== 1'b1 || o_re0 !== 13'h0100 || o_im0 !== 13'h0100 || o_sel0 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_b: vld=%b re=%h im=%h sel=%b want 1 0100 0100 1", o_vld0, o_re0, o_im0, o_sel0);
        end
        step();
        n_tests++;
        if (in_rdy0 !== 1'b1 || o_vld0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_return: in_rdy=%b vld=%b want 1 0", in_rdy0, o_vld0);
        end
    endtask

    task automatic test_rounding();
        bit ok, oka, okb;
        logic [W-1:0] ar0, ai0, ar1, ai1, br0, bi0, br1, bi1;
        logic as0, as1, bs0, bs1;
        out_rdy = 1'b1;
        send_pair(13'h0003, 13'h1FFF, 13'h0000, 13'h0000, 1'b0, ok);
        wait_out(1'b0, oka, ar0, ai0, as0, ar1, ai1, as1);
        wait_out(1'b0, okb, br0, bi0, bs0, br1, bi1, bs1);
        n_tests++;
        if (!ok || !oka || ar0 !== 13'h0001 || ai0 !== 13'h1FFF || as0 !== 1'b0) begin
            n_fail++;
            $display("FAIL floor_a: ok=%b re=%h im=%h sel=%b want 0001 1FFF 0", ok && oka, ar0, ai0, as0);
        end
        n_tests++;
        if (!okb || br0 !== 13'h0001 || bi0 !== 13'h1FFF || bs0 !== 1'b1) begin
            n_fail++;
            $display("FAIL floor_b: ok=%b re=%h im=%h sel=%b want 0001 1FFF 1", okb, br0, bi0, bs0);
        end
        n_tests++;
        if (ar1 !== 13'h0002 || ai1 !== 13'h0000 || as1 !== 1'b0) begin
            n_fail++;
            $display("FAIL round_a: re=%h im=%h sel=%b want 0002 0000 0", ar1, ai1, as1);
        end
        n_tests++;
        if (br1 !== 13'h0002 || bi1 !== 13'h0000 || bs1 !== 1'b1) begin
            n_fail++;
            $display("FAIL round_b: re=%h im=%h sel=%b want 0002 0000 1", br1, bi1, bs1);
        end
    endtask

    task automatic test_extremes();
        bit ok, oka, okb;
        logic [W-1:0] ar0, ai0, ar1, ai1, br0, bi0, br1, bi1;
        logic as0, as1, bs0, bs1;
        out_rdy = 1'b1;
        send_pair(13'h0FFF, 13'h1000, 13'h0FFF, 13'h1000, 1'b0, ok);
        wait_out(1'b0, oka, ar0, ai0, as0, ar1, ai1, as1);
        wait_out(1'b0, okb, br0, bi0, bs0, br1, bi1, bs1);
        n_tests++;
        if (!ok || !oka || ar0 !== 13'h0FFF || ai0 !== 13'h1000) begin
            n_fail++;
            $display("FAIL extreme_a: ok=%b re=%h im=%h want 0FFF 1000", ok && oka, ar0, ai0);
        end
        n_tests++;
        if (!okb || br0 !== 13'h0000 || bi0 !== 13'h0000) begin
            n_fail++;
            $display("FAIL extreme_b: ok=%b re=%h im=%h want 0000 0000", okb, br0, bi0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_rdy = 1'b0;
        send_pair(13'h0400, 13'h0600, 13'h0200, 13'h0200, 1'b0, ok);
        step();
        for (int i = 0; i < 6; i++) begin
            sr = 13'h0AAA; si = 13'h1555; dr = 13'h0123; di = 13'h0321;
            in_vld = 1'b1;
            step();
            n_tests++;
            if (!ok || o_vld0 !== 1'b1 || o_re0 !== 13'h0300 || o_im0 !== 13'h0400 ||
                o_sel0 !== 1'b0 || in_rdy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: vld=%b re=%h im=%h sel=%b in_rdy=%b want 1 0300 0400 0 0",
                         i, o_vld0, o_re0, o_im0, o_sel0, in_rdy0);
            end
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        step();
        n_tests++;
        if (o_vld0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b want 0", o_vld0);
        end
        step();
        n_tests++;
        if (o_vld0 !== 1'b1 || o_re0 !== 13'h0100 || o_im0 !== 13'h0200 || o_sel0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_b: vld=%b re=%h im=%h sel=%b want 1 0100 0200 1", o_vld0, o_re0, o_im0, o_sel0);
        end
        step();
    endtask

    task automatic test_mid_reset();
        bit ok, oka, okb;
        logic [W-1:0] ar0, ai0, ar1, ai1, br0, bi0, br1, bi1;
        logic as0, as1, bs0, bs1;
        out_rdy = 1'b0;
        send_pair(13'h0500, 13'h0300, 13'h0100, 13'h0100, 1'b0, ok);
        step();
        n_tests++;
        if (!ok || o_vld0 !== 1'b1 || o_re0 !== 13'h0300) begin
            n_fail++;
            $display("FAIL rst_pre_hold: vld=%b re=%h want 1 0300", o_vld0, o_re0);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_vld0 !== 1'b0 || o_re0 !== 13'h0 || o_im0 !== 13'h0 || o_sel0 !== 1'b0 || in_rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: vld=%b re=%h im=%h sel=%b in_rdy=%b want 0 0 0 0 1",
                     o_vld0, o_re0, o_im0, o_sel0, in_rdy0);
        end
        #1;
        rst = 1'b0;
        step();
        out_rdy = 1'b1;
        send_pair(13'h0200, 13'h0000, 13'h0200, 13'h0000, 1'b0, ok);
        wait_out(1'b0, oka, ar0, ai0, as0, ar1, ai1, as1);
        wait_out(1'b0, okb, br0, bi0, bs0, br1, bi1, bs1);
        n_tests++;
        if (!ok || !oka || ar0 !== 13'h0200 || ai0 !== 13'h0000 || as0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_next_a: re=%h im=%h sel=%b want 0200 0000 0", ar0, ai0, as0);
        end
        n_tests++;
        if (!okb || br0 !== 13'h0000 || bi0 !== 13'h0000 || bs0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_next_b: re=%h im=%h sel=%b want 0000 0000 1", br0, bi0, bs0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, oka, okb;
        logic [W-1:0] a, b, c, d;
        logic [W-1:0] ar0, ai0, ar1, ai1, br0, bi0, br1, bi1;
        logic as0, as1, bs0, bs1;
        for (int p = 0; p < 4; p++) begin
            a = W'($urandom_range(0, 8191));
            b = W'($urandom_range(0, 8191));
            c = W'($urandom_range(0, 8191));
            d = W'($urandom_range(0, 8191));
            send_pair(a, b, c, d, 1'b1, ok);
            wait_out(1'b1, oka, ar0, ai0, as0, ar1, ai1, as1);
            wait_out(1'b1, okb, br0, bi0, bs0, br1, bi1, bs1);
            n_tests++;
            if (!ok || !oka || as0 !== 1'b0 || as1 !== 1'b0 ||
                ar0 !== model(a, c, 1'b0, 0) || ai0 !== model(b, d, 1'b0, 0) ||
                ar1 !== model(a, c, 1'b0, 1) || ai1 !== model(b, d, 1'b0, 1)) begin
                n_fail++;
                $display("FAIL b2b_a%0d: sel=%b re=%h im=%h rre=%h rim=%h want 0 %h %h %h %h",
                         p, as0, ar0, ai0, ar1, ai1, model(a, c, 1'b0, 0), model(b, d, 1'b0, 0),
                         model(a, c, 1'b0, 1), model(b, d, 1'b0, 1));
            end
            n_tests++;
            if (!okb || bs0 !== 1'b1 || bs1 !== 1'b1 ||
                br0 !== model(a, c, 1'b1, 0) || bi0 !== model(b, d, 1'b1, 0) ||
                br1 !== model(a, c, 1'b1, 1) || bi1 !== model(b, d, 1'b1, 1)) begin
                n_fail++;
                $display("FAIL b2b_b%0d: sel=%b re=%h im=%h rre=%h rim=%h want 1 %h %h %h %h",
                         p, bs0, br0, bi0, br1, bi1, model(a, c, 1'b1, 0), model(b, d, 1'b1, 0),
                         model(a, c, 1'b1, 1), model(b, d, 1'b1, 1));
            end
            n_tests++;
            if (o_vld0 !== 1'b0 || in_rdy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle%0d: vld=%b in_rdy=%b want 0 1", p, o_vld0, in_rdy0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_extremes();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
